// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus bundle for the three-way memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
    logic [2:0]  i_req_valid;
    logic [2:0]  i_req_we;
    logic [95:0] i_req_addr;
    logic [95:0] i_req_wdata;
    logic [11:0] i_req_wmask;
    logic [2:0]  o_req_ack;
    logic [31:0] o_rdata;
    logic        o_err;
    logic [2:0]  o_grant;
    logic        o_mem_valid;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_ready;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_wmask,
        input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
        output o_req_ack, o_rdata, o_err, o_grant,
        output o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
    );

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_wmask,
        output i_mem_ready, i_mem_rvalid, i_mem_rdata,
        input  o_req_ack, o_rdata, o_err, o_grant,
        input  o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between CPU fetch, CPU data and DMA,
// one transaction in flight, with a per-transaction response timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic [1:0]  rr_reg;
    logic [7:0]  count_reg;
    logic [2:0]  grant_reg;
    logic [2:0]  ack_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic        mem_valid_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wmask_reg;

    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wmask [3];
    logic [1:0]  order_idx [3];
    logic [2:0]  order_valid;
    logic [1:0]  win_idx;
    logic        any_valid;

    // Slot gi of the search order holds requester (rr + gi) mod 3.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_req
            logic [2:0] rot;
            assign req_addr[gi]    = bus.i_req_addr[32*gi +: 32];
            assign req_wdata[gi]   = bus.i_req_wdata[32*gi +: 32];
            assign req_wmask[gi]   = bus.i_req_wmask[4*gi +: 4];
            assign rot             = {1'b0, rr_reg} + 3'(gi);
            assign order_idx[gi]   = (rot >= 3'd3) ? 2'(rot - 3'd3) : rot[1:0];
            assign order_valid[gi] = bus.i_req_valid[order_idx[gi]];
        end
    endgenerate

    assign any_valid = |bus.i_req_valid;
    assign win_idx   = order_valid[0] ? order_idx[0] :
                       order_valid[1] ? order_idx[1] : order_idx[2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            rr_reg        <= 2'd0;
            count_reg     <= 8'd0;
            grant_reg     <= 3'b000;
            ack_reg       <= 3'b000;
            rdata_reg     <= 32'd0;
            err_reg       <= 1'b0;
            mem_valid_reg <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            wmask_reg     <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_valid) begin
                        grant_reg     <= 3'b001 << win_idx;
                        rr_reg        <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                        we_reg        <= bus.i_req_we[win_idx];
                        addr_reg      <= req_addr[win_idx];
                        wdata_reg     <= req_wdata[win_idx];
                        wmask_reg     <= req_wmask[win_idx];
                        mem_valid_reg <= 1'b1;
                        count_reg     <= 8'd0;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    count_reg <= count_reg + 8'd1;
                    // An accept on the final allowed cycle is too late; the timeout wins.
                    if (count_reg == LAST_COUNT) begin
                        mem_valid_reg <= 1'b0;
                        rdata_reg     <= 32'd0;
                        err_reg       <= 1'b1;
                        ack_reg       <= grant_reg;
                        state_reg     <= RESP;
                    end else if (bus.i_mem_ready) begin
                        mem_valid_reg <= 1'b0;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    count_reg <= count_reg + 8'd1;
                    if (bus.i_mem_rvalid) begin
                        rdata_reg <= bus.i_mem_rdata;
                        err_reg   <= 1'b0;
                        ack_reg   <= grant_reg;
                        state_reg <= RESP;
                    end else if (count_reg == LAST_COUNT) begin
                        rdata_reg <= 32'd0;
                        err_reg   <= 1'b1;
                        ack_reg   <= grant_reg;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    ack_reg   <= 3'b000;
                    rdata_reg <= 32'd0;
                    err_reg   <= 1'b0;
                    grant_reg <= 3'b000;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ack   = ack_reg;
    assign bus.o_rdata     = rdata_reg;
    assign bus.o_err       = err_reg;
    assign bus.o_grant     = grant_reg;
    assign bus.o_mem_valid = mem_valid_reg;
    assign bus.o_mem_we    = we_reg;
    assign bus.o_mem_addr  = addr_reg;
    assign bus.o_mem_wdata = wdata_reg;
    assign bus.o_mem_wmask = wmask_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, plus
// directed read/write/contention/stall/reset/timeout scenarios with literal expectations.
module tb_mem_arbiter;
    localparam int MAIN_TO = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mem_arbiter_if bus();
    mem_arbiter_if bus_t();

    mem_arbiter #(.TIMEOUT(MAIN_TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    mem_arbiter #(.TIMEOUT(4)) dut_to (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int n, input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
        bus.i_req_valid[n]           = v;
        bus.i_req_we[n]              = we;
        bus.i_req_addr[32*n +: 32]   = addr;
        bus.i_req_wdata[32*n +: 32]  = wdata;
        bus.i_req_wmask[4*n +: 4]    = mask;
    endtask

    // Transaction-level reference: who owns the port, whether memory took the
    // command, how long it has been in flight, and whether a completion is due.
    int          m_owner = -1;
    int          m_rr = 0;
    bit          m_acc = 1'b0;
    int          m_age = 0;
    bit          m_ack = 1'b0;
    bit          m_err = 1'b0;
    logic [31:0] m_data = '0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_mask = '0;
    int          m_n;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_rr    = 0;
            m_ack   = 1'b0;
            m_acc   = 1'b0;
            m_age   = 0;
        end else if (m_ack) begin
            m_ack   = 1'b0;
            m_owner = -1;
        end else if (m_owner < 0) begin
            for (int d = 0; d < 3; d++) begin
                m_n = (m_rr + d) % 3;
                if (m_owner < 0 && bus.i_req_valid[m_n]) begin
                    m_owner = m_n;
                    m_we    = bus.i_req_we[m_n];
                    m_addr  = bus.i_req_addr[32*m_n +: 32];
                    m_wdata = bus.i_req_wdata[32*m_n +: 32];
                    m_mask  = bus.i_req_wmask[4*m_n +: 4];
                end
            end
            if (m_owner >= 0) begin
                m_rr  = (m_owner + 1) % 3;
                m_acc = 1'b0;
                m_age = 0;
            end
        end else begin
            m_age++;
            if (m_acc && bus.i_mem_rvalid) begin
                m_ack = 1'b1; m_err = 1'b0; m_data = bus.i_mem_rdata;
            end else if (m_age >= MAIN_TO) begin
                m_ack = 1'b1; m_err = 1'b1; m_data = 32'd0;
            end else if (!m_acc && bus.i_mem_ready) begin
                m_acc = 1'b1;
            end
        end
    end

    logic [2:0] ack_log[$];
    logic [2:0] eg;
    logic       emv;

    always @(negedge clk) begin
        eg  = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        emv = (m_owner >= 0) && !m_acc && !m_ack;
        chk("model_grant", 32'(bus.o_grant), 32'(eg));
        chk("model_mem_valid", 32'(bus.o_mem_valid), 32'(emv));
        if (emv) begin
            chk("model_mem_addr", bus.o_mem_addr, m_addr);
            chk("model_mem_we", 32'(bus.o_mem_we), 32'(m_we));
            chk("model_mem_wdata", bus.o_mem_wdata, m_wdata);
            chk("model_mem_wmask", 32'(bus.o_mem_wmask), 32'(m_mask));
        end
        chk("model_ack", 32'(bus.o_req_ack), m_ack ? 32'(eg) : 32'd0);
        if (m_ack) begin
            chk("model_rdata", bus.o_rdata, m_data);
            chk("model_err", 32'(bus.o_err), 32'(m_err));
        end
        if (bus.o_req_ack != 3'b000) ack_log.push_back(bus.o_req_ack);
    end

    task automatic txn(input int n, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [31:0] rdata, input logic [2:0] exp_grant);
        set_req(n, 1'b1, we, addr, wdata, mask);
        tick(1);
        chk("txn_grant", 32'(bus.o_grant), 32'(exp_grant));
        chk("txn_mem_valid", 32'(bus.o_mem_valid), 32'd1);
        chk("txn_mem_addr", bus.o_mem_addr, addr);
        chk("txn_mem_we", 32'(bus.o_mem_we), 32'(we));
        chk("txn_mem_wdata", bus.o_mem_wdata, wdata);
        chk("txn_mem_wmask", 32'(bus.o_mem_wmask), 32'(mask));
        bus.i_mem_ready = 1'b1;
        tick(1);
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = rdata;
        tick(1);
        chk("txn_ack", 32'(bus.o_req_ack), 32'(exp_grant));
        chk("txn_rdata", bus.o_rdata, rdata);
        chk("txn_err", 32'(bus.o_err), 32'd0);
        set_req(n, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.i_mem_rvalid = 1'b0;
        tick(2);
    endtask

    logic [2:0] exp_seq [4];
    int         valid_cycles;
    bit         seen;
    logic [2:0] to_ack;
    logic       to_err;
    logic       to_mv;
    logic [31:0] to_rdata;

    initial begin
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        bus.i_req_valid = '0; bus.i_req_we = '0; bus.i_req_addr = '0;
        bus.i_req_wdata = '0; bus.i_req_wmask = '0;
        bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = '0;
        bus_t.i_req_valid = '0; bus_t.i_req_we = '0; bus_t.i_req_addr = '0;
        bus_t.i_req_wdata = '0; bus_t.i_req_wmask = '0;
        bus_t.i_mem_ready = 1'b0; bus_t.i_mem_rvalid = 1'b0; bus_t.i_mem_rdata = '0;

        tick(2);
        chk("reset_grant", 32'(bus.o_grant), 32'd0);
        chk("reset_ack", 32'(bus.o_req_ack), 32'd0);
        chk("reset_mem_valid", 32'(bus.o_mem_valid), 32'd0);
        rst = 1'b0;

        // Single read and single write, minimum latency
        txn(0, 1'b0, 32'h0000FFFC, 32'd0, 4'hF, 32'h1234ABCD, 3'b001);
        txn(2, 1'b1, 32'h00000200, 32'hDEADBEEF, 4'h3, 32'h0BADF00D, 3'b100);

        // Contention with an always-ready memory
        ack_log.delete();
        bus.i_mem_ready = 1'b1; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h55AA55AA;
        for (int n = 0; n < 3; n++) set_req(n, 1'b1, 1'b0, 32'h100 * (n + 1), 32'd0, 4'hF);
        tick(15);
        for (int n = 0; n < 3; n++) set_req(n, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b0;
        tick(2);
        chk("cont_ack_count", 32'(ack_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < ack_log.size()) chk("cont_ack_order", 32'(ack_log[i]), 32'(exp_seq[i]));

        // Stall: owner req1 held while req0/req2 toggle
        set_req(1, 1'b1, 1'b0, 32'h00001110, 32'd0, 4'hF);
        tick(1);
        for (int i = 0; i < 4; i++) begin
            chk("stall_grant", 32'(bus.o_grant), 32'b010);
            chk("stall_mem_valid", 32'(bus.o_mem_valid), 32'd1);
            chk("stall_mem_addr", bus.o_mem_addr, 32'h00001110);
            set_req(0, i[0], 1'b1, 32'hA0 + i, 32'h11 * i, 4'(i));
            set_req(2, ~i[0], 1'b0, 32'hB0 + i, 32'h22 * i, 4'(i + 1));
            if (i < 3) tick(1);
        end
        bus.i_mem_ready = 1'b1;
        tick(1);
        bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hCAFEF00D;
        tick(1);
        chk("stall_ack", 32'(bus.o_req_ack), 32'b010);
        chk("stall_rdata", bus.o_rdata, 32'hCAFEF00D);
        for (int n = 0; n < 3; n++) set_req(n, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.i_mem_rvalid = 1'b0;
        tick(2);

        // Reset while req1 waits for its response
        set_req(1, 1'b1, 1'b0, 32'h00002220, 32'd0, 4'hF);
        tick(1);
        bus.i_mem_ready = 1'b1;
        tick(1);
        bus.i_mem_ready = 1'b0;
        chk("rst_pre_grant", 32'(bus.o_grant), 32'b010);
        rst = 1'b1;
        bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h00000077;
        set_req(0, 1'b1, 1'b0, 32'h00003330, 32'd0, 4'hF);
        set_req(2, 1'b1, 1'b0, 32'h00004440, 32'd0, 4'hF);
        tick(1);
        chk("rst_ack", 32'(bus.o_req_ack), 32'd0);
        chk("rst_grant", 32'(bus.o_grant), 32'd0);
        chk("rst_mem_valid", 32'(bus.o_mem_valid), 32'd0);
        chk("rst_mem_addr", bus.o_mem_addr, 32'd0);
        chk("rst_rdata", bus.o_rdata, 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        rst = 1'b0;
        bus.i_mem_rvalid = 1'b0;
        tick(1);
        chk("rst_next_grant", 32'(bus.o_grant), 32'b001);
        chk("rst_next_addr", bus.o_mem_addr, 32'h00003330);
        bus.i_mem_ready = 1'b1;
        tick(1);
        bus.i_mem_ready = 1'b0; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h00000012;
        tick(1);
        chk("rst_next_ack", 32'(bus.o_req_ack), 32'b001);
        for (int n = 0; n < 3; n++) set_req(n, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        bus.i_mem_rvalid = 1'b0;
        tick(2);

        // Timeout on the TIMEOUT=4 instance, memory never ready
        bus_t.i_req_valid = 3'b001;
        bus_t.i_req_addr[31:0] = 32'h00000040;
        valid_cycles = 0; seen = 1'b0;
        to_ack = '0; to_err = 1'b0; to_mv = 1'b1; to_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick(1);
            if (bus_t.o_req_ack != 3'b000) begin
                seen = 1'b1;
                to_ack = bus_t.o_req_ack; to_err = bus_t.o_err;
                to_rdata = bus_t.o_rdata; to_mv = bus_t.o_mem_valid;
                bus_t.i_req_valid = 3'b000;
            end else if (bus_t.o_mem_valid) begin
                valid_cycles++;
            end
        end
        bus_t.i_req_valid = 3'b000;
        chk("to_valid_cycles", 32'(valid_cycles), 32'd4);
        chk("to_ack", 32'(to_ack), 32'b001);
        chk("to_err", 32'(to_err), 32'd1);
        chk("to_rdata", to_rdata, 32'd0);
        chk("to_mem_valid_dropped", 32'(to_mv), 32'd0);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end
endmodule
